page_stream_adapter: RTL

Parametrised adapter between a page's leaf_interface user-side vectors and its user_kernel.
- Supports NUM_IN_PORTS input streams and NUM_OUT_PORTS output streams.
- Each direction of every port is decoupled by its own first-word-fall-through FIFO of depth 2^FIFO_DEPTH_BITS.
- Replaces the tied-high ap_start with a start/ready/done FSM, so the kernel runs only when input data is pending.

---
 rtl/page_stream_adapter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/page_stream_adapter.sv
// Purpose: stream adapter between leaf_interface and user_kernel: per-port FWFT FIFOs each way plus a start/ready/done FSM.
// Latency: 1 cycle from write-side accept to read-side valid in every FIFO; the FSM is fully registered.
// Backpressure: write-side ack is !full from registered count only; read side presents head word while non-empty.
// Optional: define PAGE_STREAM_ADAPTER_STATS_EN to add per-port interface-side transfer counters on stat_words.

module psa_fifo #(
    parameter int W  = 32,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign wr_rdy = (count != FULL_CNT);
    assign rd_vld = (count != '0);
    // Gate the head so an unwritten (unreset) entry never shows as X.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_vld && rd_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

module page_stream_adapter #(
    parameter int PAYLOAD_BITS    = 32,
    parameter int NUM_IN_PORTS    = 2,
    parameter int NUM_OUT_PORTS   = 2,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  kin_data,
    output logic [NUM_IN_PORTS-1:0]               kin_vld,
    input  logic [NUM_IN_PORTS-1:0]               kin_ack,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] kout_data,
    input  logic [NUM_OUT_PORTS-1:0]              kout_vld,
    output logic [NUM_OUT_PORTS-1:0]              kout_ack,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    output logic                                  kernel_start,
    input  logic                                  kernel_ready,
    input  logic                                  kernel_done,
    output logic                                  kernel_busy
`ifdef PAGE_STREAM_ADAPTER_STATS_EN
    ,
    output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*32-1:0] stat_words
`endif
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
            psa_fifo #(.W(PAYLOAD_BITS), .AW(FIFO_DEPTH_BITS)) u_fifo (
                .clk    (clk),
                .reset  (reset),
                .wr_vld (vld_interface2user[gi]),
                .wr_rdy (ack_user2interface[gi]),
                .wr_dat (dout_leaf_interface2user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .rd_vld (kin_vld[gi]),
                .rd_rdy (kin_ack[gi]),
                .rd_dat (kin_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS])
            );
        end
        for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
            psa_fifo #(.W(PAYLOAD_BITS), .AW(FIFO_DEPTH_BITS)) u_fifo (
                .clk    (clk),
                .reset  (reset),
                .wr_vld (kout_vld[gi]),
                .wr_rdy (kout_ack[gi]),
                .wr_dat (kout_data[gi*PAYLOAD_BITS +: PAYLOAD_BITS]),
                .rd_vld (vld_user2interface[gi]),
                .rd_rdy (ack_interface2user[gi]),
                .rd_dat (din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Kernel is only launched when some input FIFO holds data; done while idle is ignored.
    always_comb begin
        state_nxt    = state;
        kernel_start = 1'b0;
        kernel_busy  = 1'b0;
        case (state)
            S_IDLE: begin
                if (|kin_vld) state_nxt = S_START;
            end
            S_START: begin
                kernel_start = 1'b1;
                kernel_busy  = 1'b1;
                if (kernel_ready) state_nxt = kernel_done ? S_IDLE : S_BUSY;
            end
            S_BUSY: begin
                kernel_busy = 1'b1;
                if (kernel_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef PAGE_STREAM_ADAPTER_STATS_EN
    logic [NUM_IN_PORTS+NUM_OUT_PORTS-1:0] xfer;
    assign xfer = {vld_user2interface & ack_interface2user,
                   vld_interface2user & ack_user2interface};

    generate
        for (gi = 0; gi < NUM_IN_PORTS + NUM_OUT_PORTS; gi++) begin : g_stat
            logic [31:0] cnt;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)         cnt <= '0;
                else if (xfer[gi]) cnt <= cnt + 32'd1;
            end
            assign stat_words[gi*32 +: 32] = cnt;
        end
    endgenerate
`endif
endmodule
